// File: rtl/regfile_mp_if.sv
// regfile_mp_if: port bundle for regfile_mp.
// master drives the read, show and write requests and receives read data and oReady.
// slave is the register bank side.
interface regfile_mp_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] iReadAddr0;
    logic [ADDR_W-1:0] iReadAddr1;
    logic [DATA_W-1:0] oReadData0;
    logic [DATA_W-1:0] oReadData1;
    logic [ADDR_W-1:0] iShowAddr;
    logic [DATA_W-1:0] oShowData;
    logic              iWriteEn0;
    logic              iWriteEn1;
    logic [ADDR_W-1:0] iWriteAddr0;
    logic [ADDR_W-1:0] iWriteAddr1;
    logic [DATA_W-1:0] iWriteData0;
    logic [DATA_W-1:0] iWriteData1;
    logic              oReady;
    modport master (
        output iReadAddr0, iReadAddr1, iShowAddr,
        output iWriteEn0, iWriteEn1, iWriteAddr0, iWriteAddr1, iWriteData0, iWriteData1,
        input  oReadData0, oReadData1, oShowData, oReady
    );
    modport slave (
        input  iReadAddr0, iReadAddr1, iShowAddr,
        input  iWriteEn0, iWriteEn1, iWriteAddr0, iWriteAddr1, iWriteData0, iWriteData1,
        output oReadData0, oReadData1, oShowData, oReady
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register bank with two bypassed read ports, a show port,
// two prioritised write ports, a hard-wired zero register and a sequenced clear.
// Ports: iCLK clock; iReset synchronous active-high reset;
//        bus (slave) carries read/show addresses and data, write ports and oReady.
module regfile_mp #(
    parameter int          DATA_W  = 64,
    parameter int          ADDR_W  = 5,
    parameter int          ZR_IDX  = 31,
    parameter int          SP_IDX  = 28,
    parameter logic [63:0] SP_INIT = 64'h7fffeffc,
    parameter int          BYPASS  = 1
) (
    input logic         iCLK,
    input logic         iReset,
    regfile_mp_if.slave bus
);
    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZR     = ADDR_W'(ZR_IDX);
    localparam logic [ADDR_W-1:0] SP     = ADDR_W'(SP_IDX);
    localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);
    localparam bit                BYP    = BYPASS != 0;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run, clr_we, we0, we1;
    function automatic logic [DATA_W-1:0] rst_val(input logic [ADDR_W-1:0] a);
        return a == SP ? SP_VAL : '0;
    endfunction
    always_ff @(posedge iCLK) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        if (iReset) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            clr_we  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = &cnt_q ? RUN : CLEAR;
        end
    end
    assign run        = state_q == RUN;
    assign bus.oReady = run;
    // Port 0 is squashed on a same-address collision so port 1 always wins.
    assign we1 = run && bus.iWriteEn1 && bus.iWriteAddr1 != ZR;
    assign we0 = run && bus.iWriteEn0 && bus.iWriteAddr0 != ZR &&
                 !(we1 && bus.iWriteAddr1 == bus.iWriteAddr0);
    always_ff @(posedge iCLK) begin
        if (clr_we) begin
            mem[cnt_q] <= rst_val(cnt_q);
        end else begin
            if (we0) mem[bus.iWriteAddr0] <= bus.iWriteData0;
            if (we1) mem[bus.iWriteAddr1] <= bus.iWriteData1;
        end
    end
    // During CLEAR the array is only partly initialised, so reads report reset values.
    always_comb begin
        bus.oReadData0 = !run ? rst_val(bus.iReadAddr0) :
                         bus.iReadAddr0 == ZR ? '0 :
                         BYP && we1 && bus.iWriteAddr1 == bus.iReadAddr0 ? bus.iWriteData1 :
                         BYP && we0 && bus.iWriteAddr0 == bus.iReadAddr0 ? bus.iWriteData0 :
                         mem[bus.iReadAddr0];
        bus.oReadData1 = !run ? rst_val(bus.iReadAddr1) :
                         bus.iReadAddr1 == ZR ? '0 :
                         BYP && we1 && bus.iWriteAddr1 == bus.iReadAddr1 ? bus.iWriteData1 :
                         BYP && we0 && bus.iWriteAddr0 == bus.iReadAddr1 ? bus.iWriteData0 :
                         mem[bus.iReadAddr1];
        bus.oShowData  = !run ? rst_val(bus.iShowAddr) :
                         bus.iShowAddr == ZR ? '0 : mem[bus.iShowAddr];
    end
endmodule
